bldc_velocity_pi_loop: RTL and testbench

- Parametrised, pipelined velocity-loop controller for the BLDC drive; next generation of the fixed-width PI stage with a gain override mux.
- Takes a signed velocity setpoint and the filtered measured velocity on each control-loop pulse, and produces a signed commutation gain for the commutation stage.
- Adds over the previous generation: width/gain generics, setpoint slew limiting, integrator anti-windup, output saturation flagging, a mode select (off / open-loop / closed-loop), and stall detection with latched shutdown.

---
 rtl/bldc_velocity_pi_loop.sv | 210 +++++++++++++++++++++
 tb/tb_bldc_velocity_pi_loop.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_velocity_pi_loop.sv
// rtl/bldc_velocity_pi_loop.sv - pipelined BLDC velocity PI loop with slew, anti-windup and stall trip
//
// Purpose: on each loop_pulse, ramps the setpoint toward desired_velocity,
// runs a PI update against actual_velocity and drives a signed commutation
// gain. Supports off / open-loop / closed-loop modes and a latched stall fault.
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   enable, mode          run enable and mode select (0 off, 1 open, 2 closed, 3 off)
//   loop_pulse            single-cycle update strobe, honoured only when idle
//   desired_velocity      signed setpoint
//   actual_velocity       signed filtered measured velocity
//   kp, ki                unsigned proportional / integral gains
//   slew_step             max setpoint change per update, 0 disables limiting
//   output_gain           signed gain to the commutation stage
//   output_valid          one-cycle strobe when output_gain is refreshed
//   saturated             last closed-loop result was clamped
//   stalled               latched stall fault
module bldc_velocity_pi_loop #(
  parameter int VEL_W = 16,
  parameter int GAIN_W = 12,
  parameter int K_W = 8,
  parameter int FRAC_BITS = 4,
  parameter int INT_W = 24,
  parameter logic [GAIN_W-1:0] OPEN_LOOP_GAIN = 12'h7FF,
  parameter int STALL_VEL = 8,
  parameter int STALL_UPDATES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic                     loop_pulse,
  input  logic signed [VEL_W-1:0]  desired_velocity,
  input  logic signed [VEL_W-1:0]  actual_velocity,
  input  logic [K_W-1:0]           kp,
  input  logic [K_W-1:0]           ki,
  input  logic [VEL_W-2:0]         slew_step,
  output logic signed [GAIN_W-1:0] output_gain,
  output logic                     output_valid,
  output logic                     saturated,
  output logic                     stalled
);

  localparam int P_W = K_W + VEL_W + 2;
  // Accumulator wide enough for P + I with headroom for the carry
  localparam int A_W = ((INT_W > P_W) ? INT_W : P_W) + 2;
  localparam int C_W = $clog2(STALL_UPDATES + 1);

  localparam logic signed [A_W-1:0] INT_MAX  = A_W'((1 << (INT_W - 1)) - 1);
  localparam logic signed [A_W-1:0] INT_MIN  = -INT_MAX;
  localparam logic signed [A_W-1:0] GAIN_MAX = A_W'((1 << (GAIN_W - 1)) - 1);
  localparam logic signed [A_W-1:0] GAIN_MIN = -GAIN_MAX;
  localparam logic [GAIN_W-1:0]     OL_NEG   = -OPEN_LOOP_GAIN;
  localparam logic [VEL_W:0]        STALL_LIM = (VEL_W + 1)'(STALL_VEL);
  localparam logic [C_W-1:0]        STALL_N   = C_W'(STALL_UPDATES);

  typedef enum logic [1:0] {IDLE, RAMP, ERR, SUM} state_t;

  state_t                   state;
  logic signed [VEL_W-1:0]  ref_vel;
  logic signed [INT_W-1:0]  integ;
  logic signed [P_W-1:0]    p_reg;
  logic signed [INT_W-1:0]  i_cand_reg;
  logic                     e_neg;
  logic [C_W-1:0]           stall_cnt;

  // RAMP stage: slew-limited step of the reference toward the setpoint
  logic signed [VEL_W:0] d, slew_s, d_lim, ref_sum;
  assign d       = {desired_velocity[VEL_W-1], desired_velocity} - {ref_vel[VEL_W-1], ref_vel};
  assign slew_s  = {2'b00, slew_step};
  assign ref_sum = {ref_vel[VEL_W-1], ref_vel} + d_lim;

  always_comb begin
    d_lim = d;
    if (slew_step != '0) begin
      if (d > slew_s)
        d_lim = slew_s;
      else if (d < -slew_s)
        d_lim = -slew_s;
    end
  end

  // ERR stage: error, products and clamped integrator candidate
  logic signed [VEL_W:0]   e;
  logic signed [K_W:0]     kp_s, ki_s;
  logic signed [P_W-1:0]   p, ki_e;
  logic signed [A_W-1:0]   i_sum;
  logic signed [INT_W-1:0] i_cand;

  assign e     = {ref_vel[VEL_W-1], ref_vel} - {actual_velocity[VEL_W-1], actual_velocity};
  assign kp_s  = {1'b0, kp};
  assign ki_s  = {1'b0, ki};
  assign p     = kp_s * e;
  assign ki_e  = ki_s * e;
  assign i_sum = A_W'(integ) + A_W'(ki_e);

  always_comb begin
    i_cand = i_sum[INT_W-1:0];
    if (i_sum > INT_MAX)
      i_cand = INT_MAX[INT_W-1:0];
    else if (i_sum < INT_MIN)
      i_cand = INT_MIN[INT_W-1:0];
  end

  // SUM stage: scaled P+I, symmetric clamp so the most-negative code never appears
  logic signed [A_W-1:0]    s_full, s_shift;
  logic signed [GAIN_W-1:0] s_gain;
  logic                     s_sat;

  assign s_full  = A_W'(p_reg) + A_W'(i_cand_reg);
  assign s_shift = s_full >>> FRAC_BITS;

  always_comb begin
    s_gain = s_shift[GAIN_W-1:0];
    s_sat  = 1'b0;
    if (s_shift > GAIN_MAX) begin
      s_gain = GAIN_MAX[GAIN_W-1:0];
      s_sat  = 1'b1;
    end else if (s_shift < GAIN_MIN) begin
      s_gain = GAIN_MIN[GAIN_W-1:0];
      s_sat  = 1'b1;
    end
  end

  // Stall qualification
  logic [VEL_W:0] a_ext, a_abs;
  logic           stopped;
  logic [C_W-1:0] cnt_inc;
  logic           mode_off, mode_open;

  assign a_ext     = {actual_velocity[VEL_W-1], actual_velocity};
  assign a_abs     = a_ext[VEL_W] ? -a_ext : a_ext;
  assign stopped   = a_abs < STALL_LIM;
  assign cnt_inc   = (stall_cnt == STALL_N) ? stall_cnt : stall_cnt + 1'b1;
  assign mode_off  = !enable || (mode == 2'd0) || (mode == 2'd3);
  assign mode_open = (mode == 2'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ref_vel      <= '0;
      integ        <= '0;
      p_reg        <= '0;
      i_cand_reg   <= '0;
      e_neg        <= 1'b0;
      stall_cnt    <= '0;
      output_gain  <= '0;
      output_valid <= 1'b0;
      saturated    <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (loop_pulse)
            state <= RAMP;
        end
        RAMP: begin
          ref_vel <= ref_sum[VEL_W-1:0];
          state   <= ERR;
        end
        ERR: begin
          p_reg      <= p;
          i_cand_reg <= i_cand;
          e_neg      <= e[VEL_W];
          state      <= SUM;
        end
        SUM: begin
          state        <= IDLE;
          output_valid <= 1'b1;
          if (mode_off) begin
            // Bumpless restart: reference resumes from where the motor is
            output_gain <= '0;
            integ       <= '0;
            ref_vel     <= actual_velocity;
            saturated   <= 1'b0;
            stalled     <= 1'b0;
            stall_cnt   <= '0;
          end else if (mode_open) begin
            output_gain <= stalled ? '0 :
                           (desired_velocity[VEL_W-1] ? OL_NEG : OPEN_LOOP_GAIN);
            integ       <= '0;
            ref_vel     <= desired_velocity;
            saturated   <= 1'b0;
          end else if (stalled) begin
            output_gain <= '0;
            integ       <= '0;
            saturated   <= 1'b0;
          end else begin
            output_gain <= s_gain;
            saturated   <= s_sat;
            // Anti-windup: freeze only while pushing further into the clamp
            if (!(s_sat && (e_neg == s_shift[A_W-1])))
              integ <= i_cand_reg;
            if (s_sat && stopped) begin
              stall_cnt <= cnt_inc;
              if (cnt_inc == STALL_N)
                stalled <= 1'b1;
            end else begin
              stall_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bldc_velocity_pi_loop.sv
// tb/tb_bldc_velocity_pi_loop.sv - directed self-checking bench for bldc_velocity_pi_loop
module tb_bldc_velocity_pi_loop;

  logic               clk;
  logic               reset;
  logic               enable;
  logic [1:0]         mode;
  logic               loop_pulse;
  logic signed [15:0] desired_velocity;
  logic signed [15:0] actual_velocity;
  logic [7:0]         kp;
  logic [7:0]         ki;
  logic [14:0]        slew_step;
  logic signed [11:0] output_gain;
  logic               output_valid;
  logic               saturated;
  logic               stalled;

  int vectors;
  int miscompares;

  bldc_velocity_pi_loop dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .mode             (mode),
    .loop_pulse       (loop_pulse),
    .desired_velocity (desired_velocity),
    .actual_velocity  (actual_velocity),
    .kp               (kp),
    .ki               (ki),
    .slew_step        (slew_step),
    .output_gain      (output_gain),
    .output_valid     (output_valid),
    .saturated        (saturated),
    .stalled          (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One update: pulse for one edge, then watch six cycles for output_valid
  task automatic do_pulse(output int lat, output int nv);
    lat = -1;
    nv  = 0;
    @(negedge clk);
    loop_pulse = 1'b1;
    @(negedge clk);
    loop_pulse = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (output_valid) begin
        nv++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  task automatic off_pulse(input logic signed [15:0] act);
    int lat, nv;
    mode = 2'd0;
    actual_velocity = act;
    do_pulse(lat, nv);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    mode = 2'd0;
    loop_pulse = 1'b0;
    desired_velocity = '0;
    actual_velocity = '0;
    kp = '0;
    ki = '0;
    slew_step = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (output_gain !== 12'sd0) begin miscompares++; $display("FAIL reset_gain: got %0d expected 0", output_gain); end
    vectors++;
    if (output_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", output_valid); end
    vectors++;
    if (saturated !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b expected 0", saturated); end
    vectors++;
    if (stalled !== 1'b0) begin miscompares++; $display("FAIL reset_stalled: got %b expected 0", stalled); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, nv;
    mode = 2'd2; kp = 8'd10; ki = 8'd0; slew_step = '0;
    desired_velocity = 16'sd100; actual_velocity = 16'sd0;
    do_pulse(lat, nv);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    vectors++;
    if (nv !== 1) begin miscompares++; $display("FAIL basic_valid_count: got %0d expected 1", nv); end
    vectors++;
    if (output_gain !== 12'sd62) begin miscompares++; $display("FAIL basic_gain: got %0d expected 62", output_gain); end
    vectors++;
    if (saturated !== 1'b0) begin miscompares++; $display("FAIL basic_sat: got %b expected 0", saturated); end
  endtask

  task automatic test_saturation();
    int lat, nv;
    kp = 8'd255; desired_velocity = 16'sd1000;
    do_pulse(lat, nv);
    vectors++;
    if (output_gain !== 12'sd2047) begin miscompares++; $display("FAIL sat_pos_gain: got %0d expected 2047", output_gain); end
    vectors++;
    if (saturated !== 1'b1) begin miscompares++; $display("FAIL sat_pos_flag: got %b expected 1", saturated); end
    desired_velocity = -16'sd1000;
    do_pulse(lat, nv);
    vectors++;
    if (output_gain !== -12'sd2047) begin miscompares++; $display("FAIL sat_neg_gain: got %0d expected -2047", output_gain); end
    vectors++;
    if (saturated !== 1'b1) begin miscompares++; $display("FAIL sat_neg_flag: got %b expected 1", saturated); end
  endtask

  task automatic test_integrator();
    int lat, nv;
    logic signed [11:0] exp_gain;
    off_pulse(16'sd0);
    mode = 2'd2; kp = 8'd0; ki = 8'd16; desired_velocity = 16'sd1;
    for (int k = 1; k <= 5; k++) begin
      do_pulse(lat, nv);
      exp_gain = 12'(k);
      vectors++;
      if (output_gain !== exp_gain) begin miscompares++; $display("FAIL integ_step%0d: got %0d expected %0d", k, output_gain, exp_gain); end
    end
    // Saturate with positive error: integrator must stay at 80
    kp = 8'd255; desired_velocity = 16'sd1000;
    for (int k = 0; k < 2; k++) begin
      do_pulse(lat, nv);
      vectors++;
      if (output_gain !== 12'sd2047 || saturated !== 1'b1) begin
        miscompares++; $display("FAIL integ_windup_sat%0d: got %0d/%b expected 2047/1", k, output_gain, saturated);
      end
    end
    // Error -1: (80 - 16) >>> 4 = 4 if the integrator was frozen
    kp = 8'd0; desired_velocity = -16'sd1;
    do_pulse(lat, nv);
    vectors++;
    if (output_gain !== 12'sd4) begin miscompares++; $display("FAIL integ_unwind_gain: got %0d expected 4", output_gain); end
    vectors++;
    if (saturated !== 1'b0) begin miscompares++; $display("FAIL integ_unwind_sat: got %b expected 0", saturated); end
  endtask

  task automatic test_slew();
    int lat, nv;
    logic signed [11:0] exp_gain;
    off_pulse(16'sd0);
    mode = 2'd2; kp = 8'd16; ki = 8'd0; slew_step = 15'd10; desired_velocity = 16'sd50;
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) begin
        // Hold loop_pulse high through RAMP, ERR and SUM
        nv = 0;
        @(negedge clk);
        loop_pulse = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
          @(negedge clk);
          if (output_valid) nv++;
          if (i >= 2) loop_pulse = 1'b0;
        end
      end else begin
        do_pulse(lat, nv);
      end
      exp_gain = (k < 5) ? 12'(10 * k) : 12'sd50;
      vectors++;
      if (output_gain !== exp_gain) begin miscompares++; $display("FAIL slew_step%0d: got %0d expected %0d", k, output_gain, exp_gain); end
      vectors++;
      if (nv !== 1) begin miscompares++; $display("FAIL slew_valid_count%0d: got %0d expected 1", k, nv); end
    end
    slew_step = '0;
  endtask

  task automatic test_stall();
    int lat, nv;
    off_pulse(16'sd0);
    mode = 2'd2; kp = 8'd255; ki = 8'd0; slew_step = '0; desired_velocity = 16'sd1000;
    for (int k = 1; k <= 64; k++) begin
      do_pulse(lat, nv);
      if (k == 63) begin
        vectors++;
        if (stalled !== 1'b0) begin miscompares++; $display("FAIL stall_early: got %b expected 0", stalled); end
      end
      if (k == 64) begin
        vectors++;
        if (stalled !== 1'b1) begin miscompares++; $display("FAIL stall_trip: got %b expected 1", stalled); end
      end
    end
    do_pulse(lat, nv);
    vectors++;
    if (output_gain !== 12'sd0) begin miscompares++; $display("FAIL stall_gain: got %0d expected 0", output_gain); end
    vectors++;
    if (stalled !== 1'b1) begin miscompares++; $display("FAIL stall_latched: got %b expected 1", stalled); end
    off_pulse(16'sd3);
    vectors++;
    if (stalled !== 1'b0) begin miscompares++; $display("FAIL stall_clear: got %b expected 0", stalled); end
    vectors++;
    if (output_gain !== 12'sd0) begin miscompares++; $display("FAIL off_gain: got %0d expected 0", output_gain); end
    // ref was loaded with 3: one slew step of 1 gives error 1, gain 16*1>>>4 = 1
    mode = 2'd2; kp = 8'd16; slew_step = 15'd1; desired_velocity = 16'sd100;
    do_pulse(lat, nv);
    vectors++;
    if (output_gain !== 12'sd1) begin miscompares++; $display("FAIL off_bumpless: got %0d expected 1", output_gain); end
    slew_step = '0;
  endtask

  task automatic test_open_loop();
    int lat, nv;
    mode = 2'd1; desired_velocity = -16'sd5;
    do_pulse(lat, nv);
    vectors++;
    if (output_gain !== -12'sd2047) begin miscompares++; $display("FAIL open_neg: got %0d expected -2047", output_gain); end
    vectors++;
    if (saturated !== 1'b0) begin miscompares++; $display("FAIL open_sat: got %b expected 0", saturated); end
    desired_velocity = 16'sd5;
    do_pulse(lat, nv);
    vectors++;
    if (output_gain !== 12'sd2047) begin miscompares++; $display("FAIL open_pos: got %0d expected 2047", output_gain); end
    desired_velocity = -16'sd5;
    do_pulse(lat, nv);
  endtask

  task automatic test_reset_midpipe();
    int nv;
    nv = 0;
    @(negedge clk);
    loop_pulse = 1'b1;
    @(negedge clk);
    loop_pulse = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (output_gain !== 12'sd0) begin miscompares++; $display("FAIL midreset_gain: got %0d expected 0", output_gain); end
    vectors++;
    if (output_valid !== 1'b0 || saturated !== 1'b0 || stalled !== 1'b0) begin
      miscompares++; $display("FAIL midreset_flags: got valid %b sat %b stalled %b expected 0 0 0", output_valid, saturated, stalled);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (output_valid) nv++;
    end
    vectors++;
    if (nv !== 0) begin miscompares++; $display("FAIL midreset_no_valid: got %0d expected 0", nv); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_integrator();
    test_slew();
    test_stall();
    test_open_loop();
    test_reset_midpipe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
